// File: rtl/skid_buffer_pipe.sv
// skid_buffer_pipe
//   A chain of STAGES full-bandwidth skid-buffer register slices between an
//   ingress valid/ready interface (i_*) and an egress valid/ready interface
//   (e_*). Every slice keeps a main register M and a skid register S, which
//   gives 2*STAGES words of storage. Each handshake output is decoded from a
//   state register only, so no combinational path crosses the chain. The
//   design sustains one transfer per cycle.
//
//   Parameters
//     DATA_W  payload width in bits (>=1)
//     STAGES  number of cascaded slices (>=1)
//
//   Ports
//     clk          clock, rising edge
//     reset        asynchronous, active-high reset
//     i_valid_i    ingress valid
//     i_data_i     ingress payload
//     i_ready_o    ingress ready (decoded from slice 0 state)
//     e_ready_i    egress ready
//     e_valid_o    egress valid (decoded from last slice state)
//     e_data_o     egress payload, forced to zero while e_valid_o=0
//
//   Optional build macro SKID_PERF_CNT_EN adds:
//     stall_clr_i  synchronous clear of the stall counter (wins over increment)
//     stall_cnt_o  saturating count of cycles with e_valid_o=1 and e_ready_i=0
module skid_buffer_pipe #(
  parameter int DATA_W = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid_i,
  input  logic [DATA_W-1:0] i_data_i,
  output logic              i_ready_o,
  input  logic              e_ready_i,
  output logic              e_valid_o,
  output logic [DATA_W-1:0] e_data_o
`ifdef SKID_PERF_CNT_EN
  ,
  input  logic              stall_clr_i,
  output logic [15:0]       stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  // Per-slice handshake and data, flattened so each slice drives only its
  // own bits.
  logic [STAGES-1:0]        in_rdy;
  logic [STAGES-1:0]        out_vld;
  logic [STAGES*DATA_W-1:0] out_dat_flat;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slice
      state_t            state_q, state_d;
      logic [DATA_W-1:0] m_q, m_d;
      logic [DATA_W-1:0] s_q, s_d;
      logic              in_valid;
      logic [DATA_W-1:0] in_data;
      logic              out_ready;

      if (gi == 0) begin : g_head
        assign in_valid = i_valid_i;
        assign in_data  = i_data_i;
      end else begin : g_link
        assign in_valid = out_vld[gi-1];
        assign in_data  = out_dat_flat[(gi-1)*DATA_W +: DATA_W];
      end

      if (gi == STAGES-1) begin : g_tail
        assign out_ready = e_ready_i;
      end else begin : g_next
        assign out_ready = in_rdy[gi+1];
      end

      // Handshakes come from state alone. The unused encoding reports
      // neither ready nor valid, so no word can be lost while it recovers.
      assign in_rdy[gi]  = (state_q == ST_EMPTY) || (state_q == ST_BUSY);
      assign out_vld[gi] = (state_q == ST_BUSY) || (state_q == ST_FULL);
      assign out_dat_flat[gi*DATA_W +: DATA_W] = m_q;

      always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
          ST_EMPTY: begin
            if (in_valid) begin
              state_d = ST_BUSY;
              m_d     = in_data;
            end
          end
          ST_BUSY: begin
            if (in_valid && out_ready) begin
              // The word leaves and a new one arrives in the same cycle.
              m_d = in_data;
            end else if (in_valid) begin
              // Downstream stalled. The new word goes into the skid register.
              state_d = ST_FULL;
              s_d     = in_data;
            end else if (out_ready) begin
              state_d = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (out_ready) begin
              state_d = ST_BUSY;
              m_d     = s_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q <= ST_EMPTY;
          m_q     <= '0;
          s_q     <= '0;
        end else begin
          state_q <= state_d;
          m_q     <= m_d;
          s_q     <= s_d;
        end
      end
    end
  endgenerate

  assign i_ready_o = in_rdy[0];
  assign e_valid_o = out_vld[STAGES-1];
  assign e_data_o  = e_valid_o ? out_dat_flat[(STAGES-1)*DATA_W +: DATA_W] : '0;

`ifdef SKID_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr_i) begin
      stall_cnt_d = '0;
    end else if (e_valid_o && !e_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_skid_buffer_pipe.sv
`timescale 1ns/1ps
module tb_skid_buffer_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Two-stage DUT
  logic       v2 = 1'b0, r2 = 1'b0, ir2, ev2;
  logic [7:0] d2 = 8'h00, ed2;
  // One-stage DUT
  logic       v1 = 1'b0, r1 = 1'b0, ir1, ev1;
  logic [7:0] d1 = 8'h00, ed1;
`ifdef SKID_PERF_CNT_EN
  logic        clr2 = 1'b0, clr1 = 1'b0;
  logic [15:0] cnt2, cnt1;
`endif

  skid_buffer_pipe #(.DATA_W(8), .STAGES(2)) dut2 (
    .clk(clk), .reset(reset),
    .i_valid_i(v2), .i_data_i(d2), .i_ready_o(ir2),
    .e_ready_i(r2), .e_valid_o(ev2), .e_data_o(ed2)
`ifdef SKID_PERF_CNT_EN
    , .stall_clr_i(clr2), .stall_cnt_o(cnt2)
`endif
  );

  skid_buffer_pipe #(.DATA_W(8), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_valid_i(v1), .i_data_i(d1), .i_ready_o(ir1),
    .e_ready_i(r1), .e_valid_o(ev1), .e_data_o(ed1)
`ifdef SKID_PERF_CNT_EN
    , .stall_clr_i(clr1), .stall_cnt_o(cnt1)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboards and per-DUT bookkeeping
  logic [7:0] q2[$];
  logic [7:0] q1[$];
  int         out_cyc2[$];
  int         cyc2 = 0, cyc1 = 0, out_cnt1 = 0, held2 = 0;
  bit         acc2, acc1, prev_stall2 = 0, prev_stall1 = 0;
  logic [7:0] prev_dat2, prev_dat1;

  // One cycle on the 2-stage DUT. Inputs change on the falling edge. Outputs
  // are sampled 1 ns later, and the handshakes seen then complete on the
  // next rising edge.
  task automatic step2(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    v2 = v; d2 = d; r2 = r;
    #1;
    held2 = q2.size();
    if (prev_stall2) check_eq("stable2", ed2, prev_dat2);
    prev_stall2 = ev2 && !r2;
    prev_dat2   = ed2;
    if (ev2 && r2) begin
      out_cyc2.push_back(cyc2);
      if (q2.size() == 0) check_eq("sb_underflow2", q2.size(), 1);
      else check_eq("sb_data2", ed2, q2.pop_front());
      $display("[%0t] dut2 out 0x%02h", $time, ed2);
    end
    acc2 = v2 && ir2;
    if (acc2) q2.push_back(d2);
    cyc2++;
  endtask

  task automatic step1(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    v1 = v; d1 = d; r1 = r;
    #1;
    if (prev_stall1) check_eq("stable1", ed1, prev_dat1);
    prev_stall1 = ev1 && !r1;
    prev_dat1   = ed1;
    if (ev1 && r1) begin
      out_cnt1++;
      if (q1.size() == 0) check_eq("sb_underflow1", q1.size(), 1);
      else check_eq("sb_data1", ed1, q1.pop_front());
      $display("[%0t] dut1 out 0x%02h", $time, ed1);
    end
    acc1 = v1 && ir1;
    if (acc1) q1.push_back(d1);
    cyc1++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    int  run;
    bit  seen;
    logic [7:0] nxt;

    // Reset values
    #1;
    check_eq("rst_ready2", ir2, 1);
    check_eq("rst_valid2", ev2, 0);
    check_eq("rst_data2",  ed2, 8'h00);
    check_eq("rst_ready1", ir1, 1);
    check_eq("rst_valid1", ev1, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single word latency: visible two cycles after presentation, for one cycle
    step2(1, 8'hA5, 1);
    step2(0, 8'h00, 1);
    check_eq("lat_early", ev2, 0);
    step2(0, 8'h00, 1);
    check_eq("lat_valid", ev2, 1);
    check_eq("lat_data",  ed2, 8'hA5);
    step2(0, 8'h00, 1);
    check_eq("lat_once",  ev2, 0);
    check_eq("lat_zero",  ed2, 8'h00);

    // Back-to-back stream without backpressure
    out_cyc2.delete();
    for (int i = 0; i < 16; i++) begin
      step2(1, 8'(8'h01 + i), 1);
      check_eq("stream_acc", acc2, 1);
    end
    for (int i = 0; i < 4; i++) step2(0, 8'h00, 1);
    check_eq("stream_count", out_cyc2.size(), 16);
    if (out_cyc2.size() == 16) check_eq("stream_gapless", out_cyc2[15] - out_cyc2[0], 15);

    // Stream with a 6-cycle egress stall: ready falls with 4 words held
    nxt = 8'h20; sent = 0; seen = 0;
    out_cyc2.delete();
    for (int c = 0; c < 60 && (sent < 16 || q2.size() > 0); c++) begin
      step2(sent < 16, nxt, !(c >= 4 && c < 10));
      if (acc2) begin nxt++; sent++; end
      if (!ir2 && !seen) begin
        seen = 1;
        check_eq("held_at_full", held2, 4);
      end
    end
    check_eq("stall_ready_fell", seen, 1);
    check_eq("stall_sent", sent, 16);
    check_eq("stall_count", out_cyc2.size(), 16);
    check_eq("stall_drained", q2.size(), 0);

    // Single stage, alternating egress ready
    nxt = 8'h30; sent = 0; run = 0;
    for (int c = 0; c < 60 && (sent < 12 || q1.size() > 0); c++) begin
      step1(sent < 12, nxt, (c % 2) == 0);
      if (acc1) begin nxt++; sent++; end
      if (!ir1) begin
        run++;
        check_eq("rdy_low_run1", run <= 1, 1);
      end else begin
        run = 0;
      end
    end
    check_eq("alt_sent", sent, 12);
    check_eq("alt_count", out_cnt1, 12);
    check_eq("alt_drained", q1.size(), 0);

    // Asynchronous reset with 3 words held
    step2(1, 8'h41, 0);
    step2(1, 8'h42, 0);
    step2(1, 8'h43, 0);
    @(posedge clk);
    #3;
    check_eq("held_before_rst", q2.size(), 3);
    check_eq("valid_before_rst", ev2, 1);
    reset = 1'b1;
    #1;
    check_eq("arst_ready", ir2, 1);
    check_eq("arst_valid", ev2, 0);
    check_eq("arst_data",  ed2, 8'h00);
    q2.delete();
    prev_stall2 = 0;
    v2 = 1'b0; r2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step2(1, 8'h77, 1);
    step2(0, 8'h00, 1);
    check_eq("post_rst_early", ev2, 0);
    step2(0, 8'h00, 1);
    check_eq("post_rst_valid", ev2, 1);
    check_eq("post_rst_data",  ed2, 8'h77);
    step2(0, 8'h00, 1);
    check_eq("post_rst_nostale", ev2, 0);

`ifdef SKID_PERF_CNT_EN
    // Five stalled cycles on a held word
    check_eq("cnt_start", cnt2, 16'd0);
    step2(1, 8'h55, 1);
    step2(0, 8'h00, 0);
    for (int i = 0; i < 5; i++) step2(0, 8'h00, 0);
    step2(0, 8'h00, 1);
    check_eq("cnt_five", cnt2, 16'd5);
    // Saturation
    step2(1, 8'h66, 1);
    step2(0, 8'h00, 0);
    for (int i = 0; i < 70000; i++) @(negedge clk);
    #1;
    check_eq("cnt_sat", cnt2, 16'hFFFF);
    @(negedge clk);
    clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    #1;
    check_eq("cnt_clr", cnt2, 16'd0);
    prev_stall2 = 0;
    step2(0, 8'h00, 1);
    step2(0, 8'h00, 1);
`endif

    check_eq("final_q2", q2.size(), 0);
    check_eq("final_q1", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
